cmp_share_arbiter: RTL and testbench



---
 rtl/cmp_arb_pkg.sv | 18 +
 rtl/cmp_share_arbiter_cmp.sv | 16 +
 rtl/cmp_share_arbiter.sv | 120 ++++++++++++
 tb/tb_cmp_share_arbiter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/cmp_arb_pkg.sv
// Shared constants for the comparator-sharing arbiter: FSM encoding,
// {less,equal,greater} result codes and default sizes.
package cmp_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic [2:0] RES_LESS    = 3'b100;
  localparam logic [2:0] RES_EQUAL   = 3'b010;
  localparam logic [2:0] RES_GREATER = 3'b001;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_NREQ  = 4;

endpackage

// File: rtl/cmp_share_arbiter_cmp.sv
// Shared unsigned magnitude comparator datapath; exactly one output is high.
module cmp_share_arbiter_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             less,
  output logic             equal,
  output logic             greater
);

  assign less    = (A <  B);
  assign equal   = (A == B);
  assign greater = (A >  B);

endmodule

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter time-sharing one magnitude comparator among NREQ requesters.
// Optional macro CMP_SIGNED_EN selects two's-complement comparison.
module cmp_share_arbiter
  import cmp_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_bus,
  input  logic [NREQ*WIDTH-1:0] b_bus,
  output logic [NREQ-1:0]       gnt,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic                  less,
  output logic                  equal,
  output logic                  greater
);

  state_t           state_reg, state_next;
  logic [IDW-1:0]   ptr_reg;
  logic [IDW-1:0]   cur_id_reg;
  logic [WIDTH-1:0] op_a_reg, op_b_reg;
  logic [IDW-1:0]   rsp_id_reg;
  logic [2:0]       res_reg;

  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];
  logic [IDW-1:0]   pick_id;
  logic             pick_found;
  logic             take;

  logic [WIDTH-1:0] cmp_a, cmp_b;
  logic             cmp_less, cmp_equal, cmp_greater;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign a_arr[gi] = a_bus[gi*WIDTH +: WIDTH];
      assign b_arr[gi] = b_bus[gi*WIDTH +: WIDTH];
      assign gnt[gi]   = (state_reg == ST_GRANT) && (cur_id_reg == IDW'(gi));
    end
  endgenerate

  // First set request searching upward from the slot after the last winner.
  always_comb begin
    pick_id    = ptr_reg;
    pick_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!pick_found && req[(int'(ptr_reg) + k) % NREQ]) begin
        pick_found = 1'b1;
        pick_id    = IDW'((int'(ptr_reg) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    take       = 1'b0;
    case (state_reg)
      ST_IDLE, ST_RESP: begin
        take       = pick_found;
        state_next = pick_found ? ST_GRANT : ST_IDLE;
      end
      ST_GRANT: state_next = ST_RESP;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      ptr_reg    <= IDW'(NREQ - 1);
      cur_id_reg <= '0;
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      rsp_id_reg <= '0;
      res_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (take) begin
        ptr_reg    <= pick_id;
        cur_id_reg <= pick_id;
        op_a_reg   <= a_arr[pick_id];
        op_b_reg   <= b_arr[pick_id];
      end
      if (state_reg == ST_GRANT) begin
        res_reg    <= {cmp_less, cmp_equal, cmp_greater};
        rsp_id_reg <= cur_id_reg;
      end
    end
  end

`ifdef CMP_SIGNED_EN
  // Flipping both sign bits maps two's-complement order onto unsigned order.
  assign cmp_a = {~op_a_reg[WIDTH-1], op_a_reg[WIDTH-2:0]};
  assign cmp_b = {~op_b_reg[WIDTH-1], op_b_reg[WIDTH-2:0]};
`else
  assign cmp_a = op_a_reg;
  assign cmp_b = op_b_reg;
`endif

  cmp_share_arbiter_cmp #(.WIDTH(WIDTH)) u_cmp (
    .A       (cmp_a),
    .B       (cmp_b),
    .less    (cmp_less),
    .equal   (cmp_equal),
    .greater (cmp_greater)
  );

  assign rsp_valid = (state_reg == ST_RESP);
  assign rsp_id    = rsp_id_reg;
  assign less      = res_reg[2];
  assign equal     = res_reg[1];
  assign greater   = res_reg[0];

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed-vector bench for cmp_share_arbiter; expected values are hand-computed.
module tb_cmp_share_arbiter;
  import cmp_arb_pkg::*;

  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_bus;
  logic [NREQ*WIDTH-1:0] b_bus;
  logic [NREQ-1:0]       gnt;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic                  less, equal, greater;

  int n_vec = 0;
  int n_err = 0;

  cmp_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .a_bus     (a_bus),
    .b_bus     (b_bus),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .less      (less),
    .equal     (equal),
    .greater   (greater)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    a_bus[id*WIDTH +: WIDTH] = a;
    b_bus[id*WIDTH +: WIDTH] = b;
  endtask

  // One isolated request: grant next cycle, response the cycle after, then idle.
  task automatic one_req(input string tag, input int id, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [2:0] exp_res);
    set_ops(id, a, b);
    req = NREQ'(1) << id;
    tick();
    chk({tag, "_gnt"}, 32'(gnt), 32'(NREQ'(1) << id));
    req = '0;
    tick();
    chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_id"}, 32'(rsp_id), 32'(id));
    chk({tag, "_res"}, 32'({less, equal, greater}), 32'(exp_res));
    $display("txn %s: id=%0d a=%0d b=%0d lge=%b", tag, id, a, b, {less, equal, greater});
    tick();
    chk({tag, "_idle"}, 32'({gnt, rsp_valid}), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    a_bus = '0;
    b_bus = '0;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_out", 32'({rsp_valid, rsp_id, less, equal, greater}), 32'd0);
    reset = 1'b0;
    tick();

    // Round robin from reset pointer: 0,1,2,3,0 with all-equal operands.
    a_bus = 16'h5555;
    b_bus = 16'h5555;
    req   = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_gnt", 32'(gnt), 32'(4'b0001 << (k % 4)));
      chk("rr_novld", 32'(rsp_valid), 32'd0);
      tick();
      chk("rr_vld", 32'(rsp_valid), 32'd1);
      chk("rr_id", 32'(rsp_id), 32'(k % 4));
      chk("rr_res", 32'({less, equal, greater}), 32'(RES_EQUAL));
      $display("txn rr%0d: id=%0d lge=%b", k, rsp_id, {less, equal, greater});
    end

    // Next grant goes to 1; reset in the middle of it.
    tick();
    chk("mid_gnt", 32'(gnt), 32'h2);
    reset = 1'b1;
    #1;
    chk("async_gnt", 32'(gnt), 32'd0);
    chk("async_out", 32'({rsp_valid, rsp_id, less, equal, greater}), 32'd0);
    tick();
    chk("rst_hold", 32'({gnt, rsp_valid}), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_gnt", 32'(gnt), 32'h1);
    req = '0;
    tick();
    chk("post_rst_id", 32'(rsp_id), 32'd0);
    chk("post_rst_vld", 32'(rsp_valid), 32'd1);
    $display("txn post_rst: id=%0d lge=%b", rsp_id, {less, equal, greater});
    tick();

    // Single requests, including operand-range boundaries.
    one_req("single2", 2, 4'd9, 4'd3, RES_GREATER);
    one_req("less1", 1, 4'd0, 4'd15, RES_LESS);
    one_req("eq3", 3, 4'd15, 4'd15, RES_EQUAL);
`ifdef CMP_SIGNED_EN
    one_req("sgn_8_7", 0, 4'd8, 4'd7, RES_LESS);
    one_req("sgn_15_0", 0, 4'd15, 4'd0, RES_LESS);
`else
    one_req("uns_8_7", 0, 4'd8, 4'd7, RES_GREATER);
    one_req("uns_15_0", 0, 4'd15, 4'd0, RES_GREATER);
`endif

    // Request withdrawn before any sampling edge: nothing happens.
    req = 4'b0100;
    #3;
    req = '0;
    tick();
    chk("drop_gnt", 32'(gnt), 32'd0);
    tick();
    chk("drop_vld", 32'(rsp_valid), 32'd0);

    // Back-to-back on requester 0: grants exactly two cycles apart.
    set_ops(0, 4'd3, 4'd4);
    req = 4'b0001;
    tick();
    chk("b2b_gnt1", 32'(gnt), 32'h1);
    set_ops(0, 4'd7, 4'd2);
    tick();
    chk("b2b_gap", 32'(gnt), 32'd0);
    chk("b2b_res1", 32'({rsp_valid, less, equal, greater}), 32'({1'b1, RES_LESS}));
    $display("txn b2b1: id=%0d lge=%b", rsp_id, {less, equal, greater});
    tick();
    chk("b2b_gnt2", 32'(gnt), 32'h1);
    req = '0;
    tick();
    chk("b2b_res2", 32'({rsp_valid, less, equal, greater}), 32'({1'b1, RES_GREATER}));
    chk("b2b_id2", 32'(rsp_id), 32'd0);
    $display("txn b2b2: id=%0d lge=%b", rsp_id, {less, equal, greater});
    tick();
    chk("b2b_idle", 32'({gnt, rsp_valid}), 32'd0);
    chk("hold_res", 32'({less, equal, greater}), 32'(RES_GREATER));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
